// File: rtl/buf_ctrl_pkg.sv
// Shared types and constants for the 16x4 row-window buffer sequencer.
package buf_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_WIN,
        ST_SHIFT,
        ST_REFILL,
        ST_DONE
    } state_e;

    // A buffer row is four 32-bit words; the window is four rows tall.
    localparam int ROW_WORDS = 4;
    localparam int WIN_ROWS  = 4;

    // Buffer address layout: [5:4] row, [3:0] byte offset, upper bits zero.
    localparam int BUF_ADDR_W  = 9;
    localparam int BUF_COL_LSB = 0;
    localparam int BUF_COL_W   = 4;
    localparam int BUF_ROW_LSB = 4;
    localparam int BUF_ROW_W   = 2;

    localparam logic [1:0] LAST_WORD = 2'(ROW_WORDS - 1);
    localparam logic [1:0] LAST_ROW  = 2'(WIN_ROWS - 1);

    // Place a row index and byte column into the buffer address fields.
    function automatic logic [BUF_ADDR_W-1:0] buf_addr_pack(
        input logic [BUF_ROW_W-1:0] row,
        input logic [BUF_COL_W-1:0] col
    );
        logic [BUF_ADDR_W-1:0] a;
        a = '0;
        a[BUF_ROW_LSB +: BUF_ROW_W] = row;
        a[BUF_COL_LSB +: BUF_COL_W] = col;
        return a;
    endfunction

endpackage

// File: rtl/buf_ctrl_addr_gen.sv
// Address and counter datapath: memory word pointer, word-in-row index,
// buffer row index and loaded-row count; forms mem_addr and buf_addr.
module buf_ctrl_addr_gen
    import buf_ctrl_pkg::*;
#(
    parameter int MEM_AW = 16,
    parameter int ROW_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [MEM_AW-1:0]     base_addr,
    input  logic                  word_fire,
    input  logic                  refill,
    input  logic                  clear_k,
    input  logic                  req_active,
    input  logic                  win_active,
    input  logic [3:0]            rd_col,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [BUF_ADDR_W-1:0] buf_addr,
    output logic                  last_word,
    output logic                  last_row,
    output logic [ROW_W-1:0]      rows_loaded
);

    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [1:0]        k_q, k_d;
    logic [1:0]        row_q, row_d;
    logic [ROW_W-1:0]  rows_loaded_q, rows_loaded_d;

    // Next-state of the pointers: load on job start, advance per accepted word.
    always_comb begin
        addr_d        = addr_q;
        k_d           = k_q;
        row_d         = row_q;
        rows_loaded_d = rows_loaded_q;
        if (load) begin
            addr_d        = base_addr;
            k_d           = '0;
            row_d         = '0;
            rows_loaded_d = '0;
        end else if (clear_k) begin
            k_d = '0;
        end else if (word_fire) begin
            addr_d = addr_q + MEM_AW'(1);
            k_d    = k_q + 2'd1;
            if (k_q == LAST_WORD) begin
                rows_loaded_d = rows_loaded_q + ROW_W'(1);
                // Row index saturates at the bottom row so the FSM can see
                // "last row" steadily; refills always target the bottom row.
                if (!refill && (row_q != LAST_ROW)) begin
                    row_d = row_q + 2'd1;
                end
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q        <= '0;
            k_q           <= '0;
            row_q         <= '0;
            rows_loaded_q <= '0;
        end else begin
            addr_q        <= addr_d;
            k_q           <= k_d;
            row_q         <= row_d;
            rows_loaded_q <= rows_loaded_d;
        end
    end

    // Output address formation; both addresses read zero when unused.
    always_comb begin
        last_word   = (k_q == LAST_WORD);
        last_row    = (row_q == LAST_ROW);
        rows_loaded = rows_loaded_q;
        mem_addr    = req_active ? addr_q : '0;
        buf_addr    = '0;
        if (win_active) begin
            buf_addr = buf_addr_pack(2'b00, rd_col);
        end else if (word_fire) begin
            buf_addr = buf_addr_pack(refill ? LAST_ROW : row_q, {k_q, 2'b00});
        end
    end

endmodule

// File: rtl/buffer16x4_ctrl.sv
// Sequencer that fills a 4-row window buffer from word memory, hands the
// window to a consumer, then shifts and refills one row until the image ends.
module buffer16x4_ctrl
    import buf_ctrl_pkg::*;
#(
    parameter int MEM_AW = 16,
    parameter int ROW_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MEM_AW-1:0] base_addr,
    input  logic [ROW_W-1:0]  num_rows,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic              mem_valid,
    output logic              buf_we,
    output logic [8:0]        buf_addr,
    output logic              buf_shift_up,
    input  logic [3:0]        rd_col,
    output logic              win_valid,
    input  logic              win_ack
);

    state_e           state_q, state_d;
    logic [ROW_W-1:0] num_rows_q, num_rows_d;
    logic             load;
    logic             clear_k;
    logic             word_fire;
    logic             refill;
    logic             last_word;
    logic             last_row;
    logic [ROW_W-1:0] rows_loaded;

    buf_ctrl_addr_gen #(
        .MEM_AW (MEM_AW),
        .ROW_W  (ROW_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .base_addr   (base_addr),
        .word_fire   (word_fire),
        .refill      (refill),
        .clear_k     (clear_k),
        .req_active  (mem_rd),
        .win_active  (win_valid),
        .rd_col      (rd_col),
        .mem_addr    (mem_addr),
        .buf_addr    (buf_addr),
        .last_word   (last_word),
        .last_row    (last_row),
        .rows_loaded (rows_loaded)
    );

    // State and job-length registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            num_rows_q <= '0;
        end else begin
            state_q    <= state_d;
            num_rows_q <= num_rows_d;
        end
    end

    // Next-state and Moore/Mealy outputs; write enable follows mem_valid
    // combinationally so each returned word lands in the same cycle.
    always_comb begin
        state_d      = state_q;
        num_rows_d   = num_rows_q;
        load         = 1'b0;
        clear_k      = 1'b0;
        word_fire    = 1'b0;
        mem_rd       = 1'b0;
        buf_we       = 1'b0;
        buf_shift_up = 1'b0;
        win_valid    = 1'b0;
        done         = 1'b0;
        busy         = (state_q != ST_IDLE);
        refill       = (state_q == ST_REFILL);
        case (state_q)
            ST_IDLE: begin
                if (start && (num_rows >= ROW_W'(WIN_ROWS))) begin
                    load       = 1'b1;
                    num_rows_d = num_rows;
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                mem_rd = 1'b1;
                if (mem_valid) begin
                    word_fire = 1'b1;
                    buf_we    = 1'b1;
                    if (last_word && last_row) begin
                        state_d = ST_WIN;
                    end
                end
            end
            ST_WIN: begin
                win_valid = 1'b1;
                if (win_ack) begin
                    state_d = (rows_loaded == num_rows_q) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                buf_shift_up = 1'b1;
                clear_k      = 1'b1;
                state_d      = ST_REFILL;
            end
            ST_REFILL: begin
                mem_rd = 1'b1;
                if (mem_valid) begin
                    word_fire = 1'b1;
                    buf_we    = 1'b1;
                    if (last_word) begin
                        state_d = ST_WIN;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_buffer16x4_ctrl.sv
// Bench for buffer16x4_ctrl: a table of directed jobs, randomized jobs and
// hand-written reset / illegal-start sequences, checked against a job model.
module tb_buffer16x4_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [7:0]  num_rows;
    logic        busy;
    logic        done;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_valid;
    logic        buf_we;
    logic [8:0]  buf_addr;
    logic        buf_shift_up;
    logic [3:0]  rd_col;
    logic        win_valid;
    logic        win_ack;

    int errors = 0;
    int checks = 0;
    bit seen;

    typedef struct {
        logic [15:0] base;
        int          nrows;
        int          wt;             // memory wait cycles per word
        int          ackd;           // consumer delay before ack
        int          dup;            // cycle of a stray start pulse, -1 none
        int          exp_windows;
        int          exp_first_win;  // cycle of first win_valid after start
    } vec_t;

    localparam int NV = 5;
    vec_t tbl [NV];
    vec_t rv;

    always #5 clk = ~clk;

    buffer16x4_ctrl #(
        .MEM_AW (16),
        .ROW_W  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .num_rows     (num_rows),
        .busy         (busy),
        .done         (done),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_valid    (mem_valid),
        .buf_we       (buf_we),
        .buf_addr     (buf_addr),
        .buf_shift_up (buf_shift_up),
        .rd_col       (rd_col),
        .win_valid    (win_valid),
        .win_ack      (win_ack)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Runs one job with a responding memory and consumer, checking every
    // cycle against what the job description implies.
    task automatic run_job(input vec_t v);
        int   rd_idx    = 0;
        int   wins      = 0;
        int   shifts    = 0;
        int   wait_cnt  = 0;
        int   ack_cnt   = 0;
        int   last_ack  = -1;
        int   rewin_due = -1;
        int   total;
        bit   fin       = 0;
        bit   seen_rd   = 0;
        bit   seen_win  = 0;
        bit   prev_wait = 0;
        logic [15:0] prev_addr = '0;
        logic [15:0] exp_addr;
        logic [8:0]  exp_buf;
        total = v.nrows * 4;
        @(negedge clk);
        start = 1'b1; base_addr = v.base; num_rows = 8'(v.nrows);
        mem_valid = 1'b0; win_ack = 1'b0; rd_col = '0;
        #1 chk("start_cycle_busy", busy, 0);
        $display("job base=%h rows=%0d wait=%0d ackd=%0d", v.base, v.nrows, v.wt, v.ackd);
        for (int c = 1; c <= 3000 && !fin; c++) begin
            @(negedge clk);
            start     = (c == v.dup);
            base_addr = 16'($urandom);
            num_rows  = 8'($urandom);
            rd_col    = 4'($urandom);
            if (mem_rd) mem_valid = (wait_cnt >= v.wt);
            else        mem_valid = ($urandom_range(0, 2) == 0);
            if (win_valid) win_ack = (ack_cnt >= v.ackd);
            else           win_ack = ($urandom_range(0, 2) == 0);
            #1;
            chk("busy", busy, 1);
            chk("we_vs_valid", buf_we, mem_rd & mem_valid);
            chk("we_shift_excl", buf_we & buf_shift_up, 0);
            if (mem_rd && !seen_rd) begin
                seen_rd = 1;
                chk("first_rd_lat", c, 1);
            end
            if (prev_wait) begin
                chk("rd_hold", mem_rd, 1);
                chk("addr_hold", mem_addr, prev_addr);
            end
            if (buf_we) begin
                exp_addr = v.base + 16'(rd_idx);
                exp_buf  = (rd_idx < 16) ? 9'(rd_idx * 4) : 9'(48 + (rd_idx % 4) * 4);
                $display("rd %0d cyc %0d mem_addr=%h buf_addr=%h", rd_idx, c, mem_addr, buf_addr);
                chk("rd_mem_addr", mem_addr, exp_addr);
                chk("rd_buf_addr", buf_addr, exp_buf);
                rd_idx++;
                if (rd_idx > total) chk("extra_read", rd_idx, total);
            end
            if (win_valid) begin
                chk("win_col", buf_addr, {5'b0, rd_col});
                chk("win_no_rd", mem_rd, 0);
                chk("win_rows_full", rd_idx, (wins + 4) * 4);
                if (!seen_win) begin
                    seen_win = 1;
                    chk("first_win_lat", c, v.exp_first_win);
                end
                if (rewin_due >= 0) begin
                    chk("rewin_lat", c, rewin_due);
                    rewin_due = -1;
                end
                if (win_ack) begin
                    wins++;
                    last_ack = c;
                    $display("win %0d acked cyc %0d", wins, c);
                    if (wins < v.nrows - 3) rewin_due = c + 2 + 4 * (v.wt + 1);
                end
            end
            if (buf_shift_up) begin
                shifts++;
                $display("shift %0d cyc %0d", shifts, c);
                chk("shift_lat", c, last_ack + 1);
            end
            if (done) begin
                fin = 1;
                $display("done cyc %0d reads=%0d wins=%0d shifts=%0d", c, rd_idx, wins, shifts);
                chk("done_reads", rd_idx, total);
                chk("done_wins", wins, v.exp_windows);
                chk("done_shifts", shifts, v.nrows - 4);
                chk("done_lat", c, last_ack + 1);
            end
            prev_wait = mem_rd && !mem_valid;
            prev_addr = mem_addr;
            if (mem_rd && !mem_valid) wait_cnt++; else wait_cnt = 0;
            if (win_valid && !win_ack) ack_cnt++; else ack_cnt = 0;
        end
        if (!fin) chk("job_timeout", 0, 1);
        @(negedge clk);
        start = 1'b0; mem_valid = 1'b0; win_ack = 1'b0;
        #1;
        chk("post_busy", busy, 0);
        chk("post_done", done, 0);
    endtask

    initial begin
        tbl[0] = '{16'h0100, 4, 0, 0, -1, 1, 17};   // basic zero-wait job
        tbl[1] = '{16'h0100, 6, 0, 0, -1, 3, 17};   // multi-row job
        tbl[2] = '{16'h0200, 4, 3, 0, -1, 1, 65};   // wait-state memory
        tbl[3] = '{16'h0400, 5, 0, 2,  5, 2, 17};   // duplicate start in FILL
        tbl[4] = '{16'hFFFE, 4, 0, 0, -1, 1, 17};   // address wrap

        rst = 1'b1; start = 1'b0; mem_valid = 1'b0; win_ack = 1'b0;
        base_addr = '0; num_rows = '0; rd_col = '0;
        repeat (3) @(negedge clk);
        #1 chk("reset_outs", {busy, done, mem_rd, buf_we, buf_shift_up, win_valid, mem_addr, buf_addr}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Too-short job request is ignored; stray valid/ack in IDLE do nothing.
        @(negedge clk);
        start = 1'b1; base_addr = 16'h0500; num_rows = 8'd3;
        $display("illegal start rows=3");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0; mem_valid = 1'b1; win_ack = 1'b1;
            #1;
            chk("illegal_busy", busy, 0);
            chk("illegal_rd", mem_rd, 0);
            chk("idle_we", buf_we, 0);
        end
        mem_valid = 1'b0; win_ack = 1'b0;

        for (int i = 0; i < NV; i++) run_job(tbl[i]);

        // Reset while refilling, with a late mem_valid after reset.
        @(negedge clk);
        start = 1'b1; base_addr = 16'h0300; num_rows = 8'd6;
        $display("reset mid-job base=0300 rows=6");
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            start = 1'b0; mem_valid = mem_rd; win_ack = win_valid;
            #1;
            if (buf_shift_up) seen = 1;
        end
        chk("rst_reach_shift", seen, 1);
        @(negedge clk);
        mem_valid = mem_rd; win_ack = 1'b0; rst = 1'b1;
        #1 chk("rst_in_refill", mem_rd, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rst = 1'b0; mem_valid = (i == 0); win_ack = 1'b1;
            #1 chk("rst_outs_zero", {busy, done, mem_rd, buf_we, buf_shift_up, win_valid, mem_addr, buf_addr}, 0);
        end
        mem_valid = 1'b0; win_ack = 1'b0;
        run_job(tbl[1]);

        for (int i = 0; i < 4; i++) begin
            rv.base          = 16'($urandom);
            rv.nrows         = $urandom_range(4, 9);
            rv.wt            = $urandom_range(0, 2);
            rv.ackd          = $urandom_range(0, 3);
            rv.dup           = $urandom_range(2, 10);
            rv.exp_windows   = rv.nrows - 3;
            rv.exp_first_win = 1 + 16 * (rv.wt + 1);
            run_job(rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/buffer16x4_ctrl.md
# buffer16x4_ctrl

Sequencer for the 16x4 row-window buffer (`Buffer_16x4`). It streams rows of 128 bits (four 32-bit words) from word-addressed memory into the buffer, presents a full 4-row window to the downstream consumer, then shifts the window up one row and refills the bottom row. This repeats until `num_rows` rows have been consumed. It sits between the memory read port and the window buffer, and owns every `we`, `address` and `shift_up` the buffer sees.

## Interface
- `MEM_AW`, 16, memory word-address width
- `ROW_W`, 8, width of the row counter and of `num_rows`
- `clk` in 1: rising-edge clock
- `rst` in 1: synchronous, active-high reset
- `start` in 1: one-cycle pulse; samples `base_addr` and `num_rows`
- `base_addr` in MEM_AW: word address of row 0, word 0
- `num_rows` in ROW_W: total image rows, must be ≥4
- `busy` out 1: high from the cycle after an accepted `start` through `done`
- `done` out 1: one-cycle pulse after the last window is acked
- `mem_rd` out 1: read request, held until `mem_valid`
- `mem_addr` out MEM_AW: word address of the request
- `mem_valid` in 1: read data present on the buffer's `data_in` this cycle
- `buf_we` out 1: buffer write enable
- `buf_addr` out 9: buffer address (`[5:4]` row, `[3:0]` byte offset)
- `buf_shift_up` out 1: buffer shift
- `rd_col` in 4: consumer byte-column select, passed to `buf_addr[3:0]` while `win_valid`
- `win_valid` out 1: 4-row window stable in buffer
- `win_ack` in 1: consumer done with window

## Operation
- States: IDLE, FILL, WIN, SHIFT, REFILL, DONE.
- **IDLE**
  - `start` with `num_rows`≥4: latch `addr`=`base_addr`, `rows_loaded`=0, `row`=0, `k`=0, go to FILL.
  - `start` with `num_rows`<4: ignored.
  - `mem_valid`: ignored.
- **FILL** (loads 16 words)
  - `mem_rd`=1, `mem_addr`=`addr`.
  - On `mem_valid`, in the same cycle (combinational): `buf_we`=1, `buf_addr`={3'b0, `row`[1:0], `k`·4}.
  - Registered on `mem_valid`: `addr`++, `k`++.
  - On `k` wrap: `row`++, `rows_loaded`++.
  - After the word with `row`=3, `k`=3, go to WIN.
- **WIN**
  - `win_valid`=1, `buf_addr`={5'b0, `rd_col`}, `mem_rd`=0.
  - On `win_ack`: if `rows_loaded`==`num_rows` go to DONE, else go to SHIFT.
- **SHIFT**
  - `buf_shift_up`=1 for exactly one cycle, `buf_we`=0.
  - Then go to REFILL with `k`=0.
- **REFILL** (loads 4 words)
  - Same as FILL, with `buf_addr[5:4]`=3 fixed.
  - After `k`=3: `rows_loaded`++, go to WIN.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
- `start` while `busy` is ignored.
- `addr` wraps modulo 2^MEM_AW. `rows_loaded` never exceeds `num_rows`.
- `buf_we` and `buf_shift_up` are never high in the same cycle.
- `buf_we` is 0 whenever `mem_valid` arrives outside FILL/REFILL.
- Windows produced per job: `num_rows`−3.

## Timing
- Reset values: all outputs 0, `buf_addr`=0, state IDLE.
- `rst` mid-job:
  - Aborts with no `done`.
  - An in-flight `mem_valid` after reset is ignored.
- Latency:
  - `start` at cycle T gives `mem_rd` at T+1.
  - With a zero-wait memory (`mem_valid` in the same cycle as `mem_rd`): one word per cycle, last fill word at T+16, `win_valid` at T+17.
  - `win_ack` at cycle A gives `buf_shift_up` at A+1, `mem_rd` at A+2, and `win_valid` at A+6 (zero-wait memory).
- Handshakes:
  - `mem_rd`/`mem_addr` are stable while waiting.
  - Back-to-back requests are allowed: `mem_addr` advances the cycle after `mem_valid`.
  - `win_valid` holds until `win_ack`.
  - A `win_ack` without `win_valid` is ignored.
- `num_rows`=4: one window, then DONE; no SHIFT.

## Structure
- Package `buf_ctrl_pkg` holds:
  - the state enum;
  - `ROW_WORDS`=4, `WIN_ROWS`=4;
  - the `buf_addr` field positions.
- Sub-module `buf_ctrl_addr_gen` holds `addr`, `k`, `row` and `rows_loaded`, and forms `mem_addr`/`buf_addr`.
- The FSM stays in the top module.

## Test plan
- **Basic job, zero-wait memory:** `base_addr`=0x100, `num_rows`=4 → 16 reads at 0x100–0x10F; `buf_addr` sequence 0x00,0x04,0x08,0x0C,0x10…0x3C; `win_valid` at T+17; ack → `done`, no shift.
- **Multi-row job:** `num_rows`=6, ack each window → 3 windows; 2 `buf_shift_up` pulses; refill reads 0x110–0x113 then 0x114–0x117, all with `buf_addr[5:4]`=3; `done` once.
- **Wait-state memory:** `mem_valid` 3 cycles after each `mem_rd` → `mem_addr` held steady; `buf_we` only in valid cycles; total fill 64 cycles.
- **Illegal and duplicate start:** `start` with `num_rows`=3 → stays IDLE, `busy`=0; `start` pulsed during FILL → `base_addr` change ignored.
- **Reset mid-job:** `rst` during REFILL with `mem_valid` arriving the next cycle → all outputs 0, no `buf_we`, no `done`; a new job then runs correctly.
- **Address wrap:** `base_addr`=0xFFFE, `MEM_AW`=16, `num_rows`=4 → reads 0xFFFE, 0xFFFF, 0x0000…0x000D.
